sfp_seq: RTL and testbench

SFP_SEQ -- requirements
Module: sfp_seq

---
 rtl/sfp_seq.sv | 91 +++++++++
 tb/tb_sfp_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sfp_seq.sv
// rtl/sfp_seq.sv - per-pass sequencer for a normalizer row: accumulate rows, lockstep with a peer core, then divide.
module sfp_seq #(
  parameter int len_w   = 5,
  parameter int max_len = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [len_w-1:0] n_rows,
  input  logic             in_valid,
  output logic             in_rd,
  output logic             acc,
  output logic             sync_out,
  input  logic             sync_in,
  output logic             div,
  output logic             fifo_ext_rd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, ACC, SYNC, DIV, DRAIN, FIN} state_t;

  localparam logic [len_w-1:0] one   = len_w'(1);
  localparam logic [len_w-1:0] max_v = len_w'(max_len);

  state_t           state, state_d;
  logic [len_w-1:0] len_q, acc_cnt, div_cnt;
  logic             legal;

  assign legal       = (n_rows != '0) && (n_rows <= max_v);
  assign in_rd       = acc;
  assign fifo_ext_rd = div;

  always_comb begin
    state_d = state;
    acc     = 1'b0;
    div     = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && legal) state_d = ACC;
      end
      ACC: begin
        acc = in_valid;
        if (in_valid && (acc_cnt + one == len_q)) state_d = SYNC;
      end
      // Both cores compare the same two registered levels, so they leave SYNC on one edge.
      SYNC: if (sync_out && sync_in) state_d = DIV;
      DIV: begin
        div = 1'b1;
        if (div_cnt + one == len_q) state_d = DRAIN;
      end
      DRAIN: state_d = FIN;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      acc_cnt  <= '0;
      div_cnt  <= '0;
      sync_out <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        if (legal) begin
          len_q   <= n_rows;
          acc_cnt <= '0;
          div_cnt <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (acc) acc_cnt <= acc_cnt + one;
      if (div) div_cnt <= div_cnt + one;
      if (state == ACC && state_d == SYNC) sync_out <= 1'b1;
      if (state == DIV && state_d == DRAIN) sync_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfp_seq.sv
// tb/tb_sfp_seq.sv - scoreboard bench for sfp_seq, single core and two cores in lockstep.
module tb_sfp_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_a, start_b, in_valid, tie_self, toggle;
  logic [4:0] n_a, n_b;
  logic       in_rd_a, acc_a, sync_out_a, div_a, ext_a, busy_a, done_a, err_a;
  logic       in_rd_b, acc_b, sync_out_b, div_b, ext_b, busy_b, done_b, err_b;
  logic       sync_in_a;

  assign sync_in_a = tie_self ? sync_out_a : sync_out_b;

  sfp_seq #(.len_w(5), .max_len(16)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .n_rows(n_a), .in_valid(in_valid),
    .in_rd(in_rd_a), .acc(acc_a), .sync_out(sync_out_a), .sync_in(sync_in_a),
    .div(div_a), .fifo_ext_rd(ext_a), .busy(busy_a), .done(done_a), .err(err_a));

  sfp_seq #(.len_w(5), .max_len(16)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .n_rows(n_b), .in_valid(in_valid),
    .in_rd(in_rd_b), .acc(acc_b), .sync_out(sync_out_b), .sync_in(sync_out_a),
    .div(div_b), .fifo_ext_rd(ext_b), .busy(busy_b), .done(done_b), .err(err_b));

  typedef struct {int acc; int div; int lat; int dstart; int viol;} pass_t;
  pass_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc[2], na[2], nd[2], dst[2], viol[2], done_cnt[2];

  logic [1:0] start_v, busy_v, acc_v, rd_v, div_v, ext_v, done_v;
  assign start_v = {start_b, start_a};
  assign busy_v  = {busy_b, busy_a};
  assign acc_v   = {acc_b, acc_a};
  assign rd_v    = {in_rd_b, in_rd_a};
  assign div_v   = {div_b, div_a};
  assign ext_v   = {ext_b, ext_a};
  assign done_v  = {done_b, done_a};

  initial begin
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; na[k] = 0; nd[k] = 0; dst[k] = -1; viol[k] = 0; done_cnt[k] = 0;
    end
  end

  // Observed pass records are built mid-cycle and pushed when done fires.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pass_t p;
      cyc[k]++;
      if (start_v[k] && !busy_v[k] && !reset) begin
        cyc[k] = 0; na[k] = 0; nd[k] = 0; dst[k] = -1; viol[k] = 0;
      end
      if (acc_v[k]) na[k]++;
      if (div_v[k]) begin
        if (dst[k] < 0) dst[k] = cyc[k];
        nd[k]++;
      end
      if ((acc_v[k] && (div_v[k] || !in_valid)) || rd_v[k] != acc_v[k] || ext_v[k] != div_v[k])
        viol[k]++;
      if (done_v[k]) begin
        done_cnt[k]++;
        p = '{na[k], nd[k], cyc[k], dst[k], viol[k]};
        if (k == 0) obs_a.push_back(p);
        else        obs_b.push_back(p);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) in_valid = ~in_valid;
  endtask

  task automatic start_pass(input logic sa, input logic [4:0] va, input logic sb, input logic [4:0] vb);
    start_a = sa; n_a = va;
    start_b = sb; n_b = vb;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push_exp(input int k, input int n, input int lat, input int dstart);
    pass_t p;
    p = '{n, n, lat, dstart, 0};
    if (k == 0) exp_a.push_back(p);
    else        exp_b.push_back(p);
  endtask

  task automatic wait_pass(input int k, input string tag);
    int t = 0;
    int got;
    pass_t o, e;
    while (((k == 0) ? obs_a.size() : obs_b.size()) == 0 && t < 200) begin
      tick();
      t++;
    end
    got = (k == 0) ? obs_a.size() : obs_b.size();
    check({tag, "_done_seen"}, int'(got > 0), 1);
    if (got > 0 && ((k == 0) ? exp_a.size() : exp_b.size()) > 0) begin
      if (k == 0) begin o = obs_a.pop_front(); e = exp_a.pop_front(); end
      else        begin o = obs_b.pop_front(); e = exp_b.pop_front(); end
      check({tag, "_acc"},    o.acc,    e.acc);
      check({tag, "_div"},    o.div,    e.div);
      check({tag, "_lat"},    o.lat,    e.lat);
      check({tag, "_dstart"}, o.dstart, e.dstart);
      check({tag, "_viol"},   o.viol,   e.viol);
    end
  endtask

  function automatic int outs_a();
    return int'({acc_a, in_rd_a, div_a, ext_a, busy_a, done_a, sync_out_a, err_a});
  endfunction

  initial begin
    int dc;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; n_a = '0; n_b = '0;
    in_valid = 1'b1; tie_self = 1'b1; toggle = 1'b0;
    tick(); tick();
    check("reset_outs", outs_a(), 0);
    reset = 1'b0;
    tick();
    check("post_reset_outs", outs_a(), 0);

    start_pass(1'b1, 5'd8, 1'b0, 5'd0);
    push_exp(0, 8, 19, 10);
    wait_pass(0, "basic8");

    toggle = 1'b1; in_valid = 1'b0;
    start_pass(1'b1, 5'd4, 1'b0, 5'd0);
    push_exp(0, 4, 14, 9);
    wait_pass(0, "stall4");
    toggle = 1'b0; in_valid = 1'b1;

    tie_self = 1'b0;
    start_pass(1'b1, 5'd3, 1'b1, 5'd6);
    push_exp(0, 3, 12, 8);
    push_exp(1, 6, 15, 8);
    wait_pass(0, "lock_a");
    wait_pass(1, "lock_b");
    tie_self = 1'b1;

    start_pass(1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    check("n0_err", int'(err_a), 1);
    check("n0_busy", int'(busy_a), 0);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("err_cleared", int'(err_a), 0);

    start_pass(1'b1, 5'd16, 1'b0, 5'd0);
    push_exp(0, 16, 35, 18);
    wait_pass(0, "max16");

    start_pass(1'b1, 5'd17, 1'b0, 5'd0);
    tick();
    check("n17_err", int'(err_a), 1);
    check("n17_busy", int'(busy_a), 0);
    reset = 1'b1; tick(); reset = 1'b0; tick();

    dc = done_cnt[0];
    start_pass(1'b1, 5'd8, 1'b0, 5'd0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midreset_outs", outs_a(), 0);
    check("midreset_divs", nd[0], 2);
    reset = 1'b0;
    tick(); tick();
    check("midreset_no_done", done_cnt[0], dc);
    check("midreset_no_obs", obs_a.size(), 0);
    start_pass(1'b1, 5'd8, 1'b0, 5'd0);
    push_exp(0, 8, 19, 10);
    wait_pass(0, "fresh8");

    start_pass(1'b1, 5'd5, 1'b0, 5'd0);
    push_exp(0, 5, 13, 7);
    tick();
    start_a = 1'b1; n_a = 5'd9;
    tick();
    start_a = 1'b0;
    wait_pass(0, "busy_start");

    repeat (3) tick();
    check("done_total_a", done_cnt[0], 6);
    check("done_total_b", done_cnt[1], 1);
    check("exp_empty_a", exp_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
